alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
//   Round-robin arbiter and sequencer that shares the single combinational 8-bit
//   ALU between two requesters. It registers a winning request's operands and op
//   code, and drives the ALU's active-low select lines for SETTLE_CYCLES cycles.
//   It then captures the ALU result and returns it to the owner with a one-cycle
//   done pulse. It sits between the control logic (button/UART front ends) and
//   the ALU instance.
//
// PARAMETERS
//   WIDTH          8   operand/result width; must match the ALU
//   SETTLE_CYCLES  1   cycles operands and selects are held before capture, 1..15
//
// PORTS
//   i_Clk          in   1      system clock; all logic on the rising edge
//   i_Rst_n        in   1      synchronous reset, active low
//   i_Req0/1       in   1      request from requester 0/1; level, held until done
//   i_Op0/1        in   3      op: 0 ADD,1 SUB(abs diff),2 MULT,3 AND,4 OR,5 CMP,6-7 illegal
//   i_A0/1,i_B0/1  in   WIDTH  operands per requester
//   o_Gnt0/1       out  1      high while that requester owns the ALU
//   o_Done0/1      out  1      1-cycle pulse: o_Result valid for that owner
//   o_Err          out  1      1-cycle pulse together with o_Done on illegal op
//   o_Result       out  WIDTH  registered result; holds until the next done
//   o_Alu_A,o_Alu_B out WIDTH  registered operands to the ALU
//   o_Sub_n,o_Mult_n,o_And_n,o_Or_n,o_Compare_n  out 1  active-low ALU selects
//   i_Alu_Result   in   WIDTH  combinational ALU output
//
// BEHAVIOUR
//   - Reset (i_Rst_n low at an edge): state IDLE; all o_Gnt/o_Done/o_Err = 0;
//     o_Result = 0; o_Alu_A = o_Alu_B = 0; all selects = 1; priority pointer = 0.
//     Reset overrides any state. An in-flight operation is dropped with no done.
//   - FSM states are IDLE, EXEC and DONE.
//     IDLE: at the edge seeing any request, pick the winner. A single requester
//       wins outright. If both request, the one at the pointer wins. Register
//       A, B and op; set o_Gnt; load counter = SETTLE_CYCLES.
//       Legal op -> EXEC. Illegal op -> DONE with o_Err = 1 and o_Result = 0.
//       The pointer flips to the non-winner on every grant.
//     EXEC: selects are decoded from the registered op. ADD = all high. The
//       other ops drive exactly one low: SUB -> o_Sub_n, MULT -> o_Mult_n,
//       AND -> o_And_n, OR -> o_Or_n, CMP -> o_Compare_n.
//       The counter decrements each cycle. At the edge where counter == 1,
//       o_Result <= i_Alu_Result and the FSM goes to DONE.
//     DONE: the owner's o_Done is high for exactly this cycle, with o_Gnt still
//       high. Selects return to all high. The next edge goes to IDLE and clears
//       o_Gnt.
//   - Latency: request sampled at edge k -> o_Done high in cycle k+SETTLE_CYCLES+1.
//     For an illegal op, o_Done is high in cycle k+1.
//   - Requests are not sampled in EXEC or DONE. A request still high in IDLE is a
//     new operation using the operand values present then. Back-to-back
//     operations have a 1-cycle IDLE gap.
//   - Fairness: under continuous contention, grants alternate 0,1,0,1...
//   - Width: results are the ALU's WIDTH-bit truncated values. MULT overflow
//     wraps mod 2^WIDTH. No saturation.
//   - A requester that drops i_Req mid-operation still receives its o_Done pulse.
//     No abort path exists.
//   - o_Done0 and o_Done1 are never high together, and o_Gnt0 and o_Gnt1 are
//     never high together.
//
// TESTING
//   - Req0 only, ADD A=0x12 B=0x34, SETTLE=1 -> Gnt0; Done0 2 cycles after
//     sample; Result 0x46; selects all high.
//   - Req1, SUB A=5 B=9 -> o_Sub_n low during EXEC only; Result 0x04; Done1
//     pulse is 1 cycle.
//   - Both request in the same cycle after reset, op AND vs OR -> requester 0
//     served first, then 1. With both held high, grants alternate 0,1,0,1 for
//     6 ops.
//   - MULT 20*20 -> Result 0x90 (wrap). CMP 7,7 -> 0x01. CMP 7,8 -> 0x00.
//   - Req0 with op 6 -> no select asserted; Done0 and Err high at k+1;
//     Result 0x00.
//   - SETTLE_CYCLES=3: latency is 4 cycles. Assert i_Rst_n low during the 2nd
//     EXEC cycle -> no Done; all outputs at reset values on the next cycle; pointer
//     back to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin owner of a single shared combinational ALU.
// A winning request has its operands and op registered. The ALU selects are
// held for SETTLE_CYCLES cycles. The ALU output is then captured and returned
// to the owner with a one-cycle done pulse. Illegal op codes skip the ALU.
// They finish at once with an error pulse and a zero result.

module alu_arbiter #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_Req0,
   input  logic             i_Req1,
   input  logic [2:0]       i_Op0,
   input  logic [2:0]       i_Op1,
   input  logic [WIDTH-1:0] i_A0,
   input  logic [WIDTH-1:0] i_B0,
   input  logic [WIDTH-1:0] i_A1,
   input  logic [WIDTH-1:0] i_B1,
   output logic             o_Gnt0,
   output logic             o_Gnt1,
   output logic             o_Done0,
   output logic             o_Done1,
   output logic             o_Err,
   output logic [WIDTH-1:0] o_Result,
   output logic [WIDTH-1:0] o_Alu_A,
   output logic [WIDTH-1:0] o_Alu_B,
   output logic             o_Sub_n,
   output logic             o_Mult_n,
   output logic             o_And_n,
   output logic             o_Or_n,
   output logic             o_Compare_n,
   input  logic [WIDTH-1:0] i_Alu_Result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MULT = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_CMP  = 3'd5;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic             err_q, err_d;
   logic [2:0]       op_q, op_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] aluA_q, aluA_d;
   logic [WIDTH-1:0] aluB_q, aluB_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             winner;
   logic [2:0]       winOp;

   // Register bank; reset drops any in-flight operation without a done pulse.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         err_q    <= 1'b0;
         op_q     <= OP_ADD;
         cnt_q    <= 4'd0;
         aluA_q   <= '0;
         aluB_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         aluA_q   <= aluA_d;
         aluB_q   <= aluB_d;
         result_q <= result_d;
      end
   end

   // Arbitration and sequencing. The pointer only matters when both requesters
   // ask at once, and it always moves to the loser so contention alternates.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      err_d    = err_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      aluA_d   = aluA_q;
      aluB_d   = aluB_q;
      result_d = result_q;
      winner   = 1'b0;
      winOp    = OP_ADD;
      case (state_q)
         IDLE: begin
            if (i_Req0 || i_Req1) begin
               winner  = (i_Req0 && i_Req1) ? ptr_q : i_Req1;
               winOp   = winner ? i_Op1 : i_Op0;
               owner_d = winner;
               ptr_d   = ~winner;
               op_d    = winOp;
               aluA_d  = winner ? i_A1 : i_A0;
               aluB_d  = winner ? i_B1 : i_B0;
               cnt_d   = SETTLE_LOAD;
               if (winOp <= OP_CMP) begin
                  err_d   = 1'b0;
                  state_d = EXEC;
               end else begin
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = DONE;
               end
            end
         end
         EXEC: begin
            if (cnt_q == 4'd1) begin
               result_d = i_Alu_Result;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ALU select decode: only driven while the operands are settling, ADD is all-high.
   always_comb begin
      o_Sub_n     = 1'b1;
      o_Mult_n    = 1'b1;
      o_And_n     = 1'b1;
      o_Or_n      = 1'b1;
      o_Compare_n = 1'b1;
      if (state_q == EXEC) begin
         case (op_q)
            OP_SUB:  o_Sub_n     = 1'b0;
            OP_MULT: o_Mult_n    = 1'b0;
            OP_AND:  o_And_n     = 1'b0;
            OP_OR:   o_Or_n      = 1'b0;
            OP_CMP:  o_Compare_n = 1'b0;
            default: ;
         endcase
      end
   end

   assign o_Gnt0   = (state_q != IDLE) && !owner_q;
   assign o_Gnt1   = (state_q != IDLE) && owner_q;
   assign o_Done0  = (state_q == DONE) && !owner_q;
   assign o_Done1  = (state_q == DONE) && owner_q;
   assign o_Err    = (state_q == DONE) && err_q;
   assign o_Result = result_q;
   assign o_Alu_A  = aluA_q;
   assign o_Alu_B  = aluB_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// u0 runs with SETTLE_CYCLES=1 and u3 with SETTLE_CYCLES=3.

module tb_alu_arbiter;

   typedef struct {
      int         owner;
      logic [7:0] res;
      logic       err;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   logic       clk = 1'b0;
   logic       rstN, rst3N;
   logic       req0, req1, r3Req0, r3Req1;
   logic [2:0] op0, op1;
   logic [7:0] a0, b0, a1, b1;

   logic       gnt0, gnt1, done0, done1, err;
   logic [7:0] result, aluA, aluB, aluRes;
   logic       subN, multN, andN, orN, cmpN;
   logic [4:0] sel;

   logic       g30, g31, d30, d31, err3;
   logic [7:0] result3, aluA3, aluB3, aluRes3;
   logic       subN3, multN3, andN3, orN3, cmpN3;
   logic [4:0] sel3;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Behavioural ALU: whichever active-low select is asserted picks the op,
   // and with no select asserted the ALU adds.
   function automatic logic [7:0] tbAlu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] s);
      logic [7:0] r;
      if (!s[4])      r = (a > b) ? a - b : b - a;
      else if (!s[3]) r = a * b;
      else if (!s[2]) r = a & b;
      else if (!s[1]) r = a | b;
      else if (!s[0]) r = {7'd0, a == b};
      else            r = a + b;
      return r;
   endfunction

   // Expected result of a whole operation, taken from the op code alone.
   function automatic logic [7:0] expResult(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
      logic [7:0] r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = (a > b) ? a - b : b - a;
         3'd2:    r = a * b;
         3'd3:    r = a & b;
         3'd4:    r = a | b;
         3'd5:    r = {7'd0, a == b};
         default: r = 8'd0;
      endcase
      return r;
   endfunction

   // Expected EXEC select pattern {sub,mult,and,or,cmp} for an op code.
   function automatic logic [4:0] expSel(input logic [2:0] op);
      logic [4:0] s;
      case (op)
         3'd1:    s = 5'b01111;
         3'd2:    s = 5'b10111;
         3'd3:    s = 5'b11011;
         3'd4:    s = 5'b11101;
         3'd5:    s = 5'b11110;
         default: s = 5'b11111;
      endcase
      return s;
   endfunction

   assign sel     = {subN, multN, andN, orN, cmpN};
   assign aluRes  = tbAlu(aluA, aluB, sel);
   assign sel3    = {subN3, multN3, andN3, orN3, cmpN3};
   assign aluRes3 = tbAlu(aluA3, aluB3, sel3);

   alu_arbiter #(.WIDTH(8), .SETTLE_CYCLES(1)) u0 (
      .i_Clk(clk), .i_Rst_n(rstN), .i_Req0(req0), .i_Req1(req1),
      .i_Op0(op0), .i_Op1(op1), .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1),
      .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Done0(done0), .o_Done1(done1), .o_Err(err),
      .o_Result(result), .o_Alu_A(aluA), .o_Alu_B(aluB),
      .o_Sub_n(subN), .o_Mult_n(multN), .o_And_n(andN), .o_Or_n(orN),
      .o_Compare_n(cmpN), .i_Alu_Result(aluRes)
   );

   alu_arbiter #(.WIDTH(8), .SETTLE_CYCLES(3)) u3 (
      .i_Clk(clk), .i_Rst_n(rst3N), .i_Req0(r3Req0), .i_Req1(r3Req1),
      .i_Op0(op0), .i_Op1(op1), .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1),
      .o_Gnt0(g30), .o_Gnt1(g31), .o_Done0(d30), .o_Done1(d31), .o_Err(err3),
      .o_Result(result3), .o_Alu_A(aluA3), .o_Alu_B(aluB3),
      .o_Sub_n(subN3), .o_Mult_n(multN3), .o_And_n(andN3), .o_Or_n(orN3),
      .o_Compare_n(cmpN3), .i_Alu_Result(aluRes3)
   );

   // Scoreboard for u0: every done pulse pops the oldest expectation and is
   // compared against it; mutual exclusion of grants and dones is checked too.
   always @(negedge clk) begin
      exp_t e;
      if (rstN) begin
         if (gnt0 && gnt1) begin
            errors++;
            $display("[TB] FAIL gnt_exclusive: gnt0=%0b gnt1=%0b required not both", gnt0, gnt1);
         end
         if (done0 && done1) begin
            errors++;
            $display("[TB] FAIL done_exclusive: done0=%0b done1=%0b required not both", done0, done1);
         end
         if (done0 || done1) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_unexpected: done0=%0b done1=%0b with empty queue", done0, done1);
            end else begin
               e = sbq.pop_front();
               if (int'(done1) !== e.owner) begin
                  errors++;
                  $display("[TB] FAIL sb_owner: got %0d required %0d", int'(done1), e.owner);
               end
               checks++;
               if (result !== e.res) begin
                  errors++;
                  $display("[TB] FAIL sb_result: got 0x%02h required 0x%02h", result, e.res);
               end
               checks++;
               if (err !== e.err) begin
                  errors++;
                  $display("[TB] FAIL sb_err: got %0b required %0b", err, e.err);
               end
            end
         end
      end
   end

   // Drive one request on u0, push its expectation, and report what was seen
   // at the sampling edge, at the done cycle and on the cycle after done.
   task automatic run_single(input int who, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, output int lat, output logic [4:0] selExec,
                             output logic [4:0] selDone, output logic gntSample,
                             output logic gntDone, output logic errDone,
                             output logic postBusy);
      exp_t e;
      @(negedge clk);
      if (who == 0) begin
         req0 = 1'b1; op0 = op; a0 = a; b0 = b;
      end else begin
         req1 = 1'b1; op1 = op; a1 = a; b1 = b;
      end
      e.owner = who;
      e.res   = expResult(op, a, b);
      e.err   = (op > 3'd5);
      sbq.push_back(e);
      @(posedge clk); #1;
      gntSample = (who == 1) ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
      selExec   = sel;
      lat       = 0;
      while (!((who == 1) ? done1 : done0) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      gntDone = (who == 1) ? gnt1 : gnt0;
      errDone = err;
      selDone = sel;
      req0    = 1'b0;
      req1    = 1'b0;
      @(posedge clk); #1;
      postBusy = gnt0 | gnt1 | done0 | done1 | err;
   endtask

   // Both instances in reset: every output at its reset value.
   task automatic test_reset();
      rstN = 1'b0; rst3N = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({gnt0, gnt1, done0, done1, err} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %05b required 00000", {gnt0, gnt1, done0, done1, err});
      end
      checks++;
      if ({result, aluA, aluB} !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %06h required 000000", {result, aluA, aluB});
      end
      checks++;
      if (sel !== 5'b11111) begin
         errors++;
         $display("[TB] FAIL reset_sel: got %05b required 11111", sel);
      end
      checks++;
      if ({g30, g31, d30, d31, err3, sel3} !== 10'b0000011111) begin
         errors++;
         $display("[TB] FAIL reset_u3: got %010b required 0000011111", {g30, g31, d30, d31, err3, sel3});
      end
      @(negedge clk);
      rstN = 1'b1; rst3N = 1'b1;
   endtask

   // ADD from requester 0: grant at the sample, done one edge later, no selects.
   task automatic test_add();
      int lat; logic [4:0] sE, sD; logic gS, gD, eD, pB;
      run_single(0, 3'd0, 8'h12, 8'h34, lat, sE, sD, gS, gD, eD, pB);
      checks++;
      if (gS !== 1'b1) begin errors++; $display("[TB] FAIL add_gnt: got %0b required 1", gS); end
      checks++;
      if (lat !== 1) begin errors++; $display("[TB] FAIL add_latency: got %0d required 1", lat); end
      checks++;
      if (sE !== 5'b11111) begin errors++; $display("[TB] FAIL add_sel: got %05b required 11111", sE); end
      checks++;
      if (gD !== 1'b1) begin errors++; $display("[TB] FAIL add_gnt_at_done: got %0b required 1", gD); end
      checks++;
      if (pB !== 1'b0) begin errors++; $display("[TB] FAIL add_idle_after: got %0b required 0", pB); end
   endtask

   // SUB from requester 1: Sub_n low only while executing, single-cycle done.
   task automatic test_sub();
      int lat; logic [4:0] sE, sD; logic gS, gD, eD, pB;
      run_single(1, 3'd1, 8'd5, 8'd9, lat, sE, sD, gS, gD, eD, pB);
      checks++;
      if (gS !== 1'b1) begin errors++; $display("[TB] FAIL sub_gnt: got %0b required 1", gS); end
      checks++;
      if (sE !== 5'b01111) begin errors++; $display("[TB] FAIL sub_sel_exec: got %05b required 01111", sE); end
      checks++;
      if (sD !== 5'b11111) begin errors++; $display("[TB] FAIL sub_sel_done: got %05b required 11111", sD); end
      checks++;
      if (pB !== 1'b0) begin errors++; $display("[TB] FAIL sub_done_width: got %0b required 0", pB); end
   endtask

   // MULT with wrap-around and both CMP outcomes, checking the select decode.
   task automatic test_mult_cmp();
      int lat; logic [4:0] sE, sD; logic gS, gD, eD, pB;
      logic [2:0] ops[3] = '{3'd2, 3'd5, 3'd5};
      logic [7:0] as[3]  = '{8'd20, 8'd7, 8'd7};
      logic [7:0] bs[3]  = '{8'd20, 8'd7, 8'd8};
      for (int i = 0; i < 3; i++) begin
         run_single(i % 2, ops[i], as[i], bs[i], lat, sE, sD, gS, gD, eD, pB);
         checks++;
         if (sE !== expSel(ops[i])) begin
            errors++;
            $display("[TB] FAIL mc_sel%0d: got %05b required %05b", i, sE, expSel(ops[i]));
         end
         checks++;
         if (lat !== 1) begin errors++; $display("[TB] FAIL mc_latency%0d: got %0d required 1", i, lat); end
      end
   endtask

   // Illegal op: done and err immediately, zero result, no select asserted.
   task automatic test_illegal();
      int lat; logic [4:0] sE, sD; logic gS, gD, eD, pB;
      run_single(0, 3'd6, 8'hAA, 8'h55, lat, sE, sD, gS, gD, eD, pB);
      checks++;
      if (lat !== 0) begin errors++; $display("[TB] FAIL ill_latency: got %0d required 0", lat); end
      checks++;
      if (eD !== 1'b1) begin errors++; $display("[TB] FAIL ill_err: got %0b required 1", eD); end
      checks++;
      if (sE !== 5'b11111) begin errors++; $display("[TB] FAIL ill_sel: got %05b required 11111", sE); end
   endtask

   // Both requesters held high from reset: grants alternate starting with 0.
   task automatic test_contention();
      exp_t e;
      int   seq[6];
      int   n = 0;
      int   cyc = 0;
      rstN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      op0 = 3'd3; a0 = 8'h3C; b0 = 8'h0F;
      op1 = 3'd4; a1 = 8'h50; b1 = 8'h0A;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         seq[i]  = -1;
         e.owner = i % 2;
         e.res   = (i % 2 == 0) ? expResult(3'd3, 8'h3C, 8'h0F) : expResult(3'd4, 8'h50, 8'h0A);
         e.err   = 1'b0;
         sbq.push_back(e);
      end
      while (n < 6 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (done0 || done1) begin
            seq[n] = int'(done1);
            n++;
            if (n == 6) begin req0 = 1'b0; req1 = 1'b0; end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n !== 6) begin errors++; $display("[TB] FAIL cont_count: got %0d required 6", n); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (seq[i] !== i % 2) begin
            errors++;
            $display("[TB] FAIL cont_order%0d: got %0d required %0d", i, seq[i], i % 2);
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // SETTLE_CYCLES=3: done three edges after the sampling edge.
   task automatic test_settle3_latency();
      int lat = 0;
      @(negedge clk);
      op0 = 3'd0; a0 = 8'd3; b0 = 8'd4;
      r3Req0 = 1'b1;
      @(posedge clk); #1;
      while (!d30 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 3) begin errors++; $display("[TB] FAIL s3_latency: got %0d required 3", lat); end
      checks++;
      if (result3 !== 8'd7) begin errors++; $display("[TB] FAIL s3_result: got 0x%02h required 0x07", result3); end
      r3Req0 = 1'b0;
      @(posedge clk); #1;
   endtask

   // Reset in the second EXEC cycle drops the op and returns the pointer to 0.
   task automatic test_settle3_reset();
      int  cyc = 0;
      logic sawDone = 1'b0;
      @(negedge clk);
      op0 = 3'd1; a0 = 8'd1; b0 = 8'd2;
      r3Req0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst3N = 1'b0; r3Req0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({g30, g31, d30, d31, err3, sel3} !== 10'b0000011111) begin
         errors++;
         $display("[TB] FAIL s3rst_flags: got %010b required 0000011111", {g30, g31, d30, d31, err3, sel3});
      end
      checks++;
      if ({result3, aluA3, aluB3} !== 24'h0) begin
         errors++;
         $display("[TB] FAIL s3rst_data: got %06h required 000000", {result3, aluA3, aluB3});
      end
      @(negedge clk);
      rst3N = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (d30 || d31) sawDone = 1'b1;
      end
      checks++;
      if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL s3rst_nodone: got %0b required 0", sawDone); end
      @(negedge clk);
      op0 = 3'd0; a0 = 8'd1; b0 = 8'd1;
      op1 = 3'd0; a1 = 8'd2; b1 = 8'd2;
      r3Req0 = 1'b1; r3Req1 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({g30, g31} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL s3rst_pointer: got gnt0/1=%02b required 10", {g30, g31});
      end
      while (!(d30 || d31) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      r3Req0 = 1'b0; r3Req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Test sequence and summary.
   initial begin
      req0 = 1'b0; req1 = 1'b0; r3Req0 = 1'b0; r3Req1 = 1'b0;
      op0 = 3'd0; op1 = 3'd0; a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
      rstN = 1'b0; rst3N = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_mult_cmp();
      test_illegal();
      test_contention();
      test_settle3_latency();
      test_settle3_reset();
      checks++;
      if (sbq.size() !== 0) begin
         errors++;
         $display("[TB] FAIL sb_leftover: got %0d pending required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
